if_fetch: RTL

Instruction-fetch stage front end. Holds the program counter and issues single-outstanding requests to instruction memory. It returns fetched words with their PC on if_pc/if_inst/if_valid, which the IF/ID pipeline register samples. It also handles downstream stall, which backpressure-buffers the response, and redirect (branch/exception), which retargets the PC and discards stale responses.

---
 rtl/if_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch front end: program counter plus a single-outstanding imem request,
// a one-entry skid for responses that arrive while IF/ID stalls, and redirect/flush handling.
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [DATA_W-1:0] out_inst_q, out_inst_d;
    logic              out_vld_q, out_vld_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
    logic              drop_q, drop_d;
    logic              consume;
    logic [ADDR_W-1:0] pc_inc;
    logic              unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_comb begin
        consume     = out_vld_q && !stall;
        pc_inc      = pc_q + ADDR_W'(4);
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_vld_d   = out_vld_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        drop_d      = drop_q;

        if (consume) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!out_vld_q || !stall) begin
                        out_pc_d   = pc_q;
                        out_inst_d = imem_rdata;
                        out_vld_d  = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = S_REQ;
                    end else begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem_rdata;
                        pc_d        = pc_inc;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (consume) begin
                    out_pc_d   = skid_pc_q;
                    out_inst_d = skid_inst_q;
                    out_vld_d  = 1'b1;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over everything; an in-flight response becomes stale and is dropped.
        if (redirect_en) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            out_pc_d   = out_pc_q;
            out_inst_d = out_inst_q;
            out_vld_d  = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            out_vld_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            out_vld_q  <= out_vld_d;
            drop_q     <= drop_d;
        end
    end

    // Skid contents are only meaningful in HOLD, so they need no reset.
    always_ff @(posedge clk) begin
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_pc     = out_pc_q;
    assign if_inst   = out_inst_q;
    assign if_valid  = out_vld_q;

endmodule
